// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and operand resolution for the ID hazard/forwarding unit
// Contents: wb_kind encodings, forwarding select codes, scoreboard slot type,
//           resolve_operand() helper returning {stall, select} for one source operand.
package hazard_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LINK = 2'd1;
    localparam logic [1:0] WB_LOAD = 2'd2;

    localparam logic [2:0] FWD_REGFILE   = 3'd0;
    localparam logic [2:0] FWD_IDEX_PC4  = 3'd1;
    localparam logic [2:0] FWD_EXMEM_RES = 3'd2;
    localparam logic [2:0] FWD_EXMEM_PC4 = 3'd3;
    localparam logic [2:0] FWD_WB        = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [4:0] wr_reg;
        logic [1:0] wb_kind;
    } sb_slot_t;

    function automatic logic slot_match(input sb_slot_t slot, input logic [4:0] src,
                                        input logic used);
        return slot.valid && (slot.wr_reg == src) && (src != 5'd0) && used;
    endfunction

    // Youngest producer wins. A producer whose value is not yet available on any
    // forwarding path turns into a stall for this operand; the select is then
    // left at the regfile code since the instruction will not proceed.
    function automatic logic [3:0] resolve_operand(input sb_slot_t ex, input sb_slot_t mem,
                                                   input sb_slot_t wb, input logic [4:0] src,
                                                   input logic used);
        logic       stl;
        logic [2:0] sel;
        stl = 1'b0;
        sel = FWD_REGFILE;
        if (slot_match(ex, src, used)) begin
            if (ex.wb_kind == WB_LINK) sel = FWD_IDEX_PC4;
            else                       stl = 1'b1;
        end else if (slot_match(mem, src, used)) begin
            if (mem.wb_kind == WB_ALU)       sel = FWD_EXMEM_RES;
            else if (mem.wb_kind == WB_LINK) sel = FWD_EXMEM_PC4;
            else                             stl = 1'b1;
        end else if (slot_match(wb, src, used)) begin
            sel = FWD_WB;
        end
        return {stl, sel};
    endfunction

endpackage

// File: rtl/hilo_busy_ctr.sv
// rtl/hilo_busy_ctr.sv - HI/LO busy countdown loaded by accepted mult/div starts
// Ports: clk, rst (sync, active-high), load_mult, load_div (div wins when both),
//        busy (counter nonzero).
module hilo_busy_ctr #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32,
    parameter int CTR_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_mult,
    input  logic load_div,
    output logic busy
);

    logic [CTR_W-1:0] cnt;

    // A new start always reloads, so the most recently started op sets the wait.
    always_ff @(posedge clk) begin
        if (rst)                  cnt <= '0;
        else if (load_div)        cnt <= CTR_W'(DIV_LAT);
        else if (load_mult)       cnt <= CTR_W'(MULT_LAT);
        else if (cnt != '0)       cnt <= cnt - CTR_W'(1);
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/id_hazard_fwd_unit.sv
// rtl/id_hazard_fwd_unit.sv - decode-stage hazard detection and forwarding select generation
// Ports: clk, rst (sync, active-high); ID instruction fields id_rs/id_rt/*_used,
//        id_wr_reg/id_wr_en/id_wb_kind, id_is_mfhilo, id_start_mult/id_start_div;
//        outputs IF_ID_rs_FUnit_o/IF_ID_rt_FUnit_o (forward selects), stall, hilo_busy.
// Macro HAZ_DIV_EN: when defined, divide starts are tracked and DIV_LAT sizes the counter.
module id_hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [4:0] id_wr_reg,
    input  logic       id_wr_en,
    input  logic [1:0] id_wb_kind,
    input  logic       id_is_mfhilo,
    input  logic       id_start_mult,
    input  logic       id_start_div,
    output logic [2:0] IF_ID_rs_FUnit_o,
    output logic [2:0] IF_ID_rt_FUnit_o,
    output logic       stall,
    output logic       hilo_busy
);

`ifdef HAZ_DIV_EN
    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    logic start_div;
    assign start_div = id_start_div;
`else
    localparam int MAX_LAT = MULT_LAT;
    logic start_div;
    logic unused_start_div;
    assign start_div        = 1'b0;
    assign unused_start_div = id_start_div;
`endif
    localparam int CTR_W = $clog2(MAX_LAT + 1);

    sb_slot_t sb_ex, sb_mem, sb_wb;
    logic [3:0] rs_res, rt_res;

    assign rs_res = resolve_operand(sb_ex, sb_mem, sb_wb, id_rs, id_rs_used);
    assign rt_res = resolve_operand(sb_ex, sb_mem, sb_wb, id_rt, id_rt_used);

    assign IF_ID_rs_FUnit_o = rs_res[2:0];
    assign IF_ID_rt_FUnit_o = rt_res[2:0];
    assign stall            = rs_res[3] | rt_res[3] | (id_is_mfhilo & hilo_busy);

    // A stalled ID instruction stays in IF/ID, so EX receives a bubble instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_ex  <= '0;
            sb_mem <= '0;
            sb_wb  <= '0;
        end else begin
            sb_wb  <= sb_mem;
            sb_mem <= sb_ex;
            if (stall) sb_ex <= '0;
            else       sb_ex <= '{valid: id_wr_en, wr_reg: id_wr_reg, wb_kind: id_wb_kind};
        end
    end

    hilo_busy_ctr #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CTR_W    (CTR_W)
    ) u_hilo_busy_ctr (
        .clk       (clk),
        .rst       (rst),
        .load_mult (id_start_mult & ~stall),
        .load_div  (start_div & ~stall),
        .busy      (hilo_busy)
    );

endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// tb/tb_id_hazard_fwd_unit.sv - scoreboard bench for id_hazard_fwd_unit
module tb_id_hazard_fwd_unit;

    localparam logic [1:0] K_ALU  = 2'd0;
    localparam logic [1:0] K_LINK = 2'd1;
    localparam logic [1:0] K_LOAD = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_wr_reg;
    logic       id_rs_used, id_rt_used, id_wr_en;
    logic [1:0] id_wb_kind;
    logic       id_is_mfhilo, id_start_mult, id_start_div;
    logic [2:0] rs_sel, rt_sel;
    logic       stall, hilo_busy;

    typedef struct {
        string      name;
        bit         chk_sel;
        bit         chk_ctl;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       st;
        logic       bz;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    id_hazard_fwd_unit #(.MULT_LAT(4), .DIV_LAT(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rs_used       (id_rs_used),
        .id_rt_used       (id_rt_used),
        .id_wr_reg        (id_wr_reg),
        .id_wr_en         (id_wr_en),
        .id_wb_kind       (id_wb_kind),
        .id_is_mfhilo     (id_is_mfhilo),
        .id_start_mult    (id_start_mult),
        .id_start_div     (id_start_div),
        .IF_ID_rs_FUnit_o (rs_sel),
        .IF_ID_rt_FUnit_o (rt_sel),
        .stall            (stall),
        .hilo_busy        (hilo_busy)
    );

    task automatic set_id(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                          input logic rtu, input logic [4:0] wr, input logic wen,
                          input logic [1:0] kind, input logic mf, input logic sm,
                          input logic sd);
        id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_wr_reg = wr; id_wr_en = wen; id_wb_kind = kind;
        id_is_mfhilo = mf; id_start_mult = sm; id_start_div = sd;
    endtask

    // Inputs are already applied at this negedge; queue what they should produce,
    // then advance one cycle.
    task automatic cyc(input string nm, input bit cs, input bit cc, input logic [2:0] ers,
                       input logic [2:0] ert, input logic est, input logic ebz);
        exp_t e;
        e.name = nm; e.chk_sel = cs; e.chk_ctl = cc;
        e.rs = ers; e.rt = ert; e.st = est; e.bz = ebz;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_sel) begin
                    check({e.name, ".rs_sel"}, 32'(rs_sel), 32'(e.rs));
                    check({e.name, ".rt_sel"}, 32'(rt_sel), 32'(e.rt));
                end
                if (e.chk_ctl) begin
                    check({e.name, ".stall"}, 32'(stall), 32'(e.st));
                    check({e.name, ".hilo_busy"}, 32'(hilo_busy), 32'(e.bz));
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, K_ALU, 0, 0, 0);
        @(negedge clk);
        cyc("rst_first", 0, 0, 0, 0, 0, 0);
        set_id(3, 1, 3, 1, 3, 1, K_LOAD, 1, 0, 0);
        cyc("reset_state", 1, 1, 0, 0, 0, 0);
        rst = 1'b0;

        // ALU producer r5 directly ahead
        set_id(1, 1, 2, 1, 5, 1, K_ALU, 0, 0, 0);  cyc("alu_prod", 1, 1, 0, 0, 0, 0);
        set_id(5, 1, 6, 1, 8, 1, K_ALU, 0, 0, 0);  cyc("alu_dep_stall", 0, 1, 0, 0, 1, 0);
                                                   cyc("alu_dep_fwd", 1, 1, 2, 0, 0, 0);
        set_id(5, 1, 0, 1, 0, 0, K_ALU, 0, 0, 0);  cyc("alu_dep_wb", 1, 1, 4, 0, 0, 0);
        set_id(0, 0, 0, 0, 0, 0, K_ALU, 0, 0, 0);  cyc("idle1", 1, 1, 0, 0, 0, 0);

        // load r7, dependent reads rt=r7
        set_id(1, 1, 0, 0, 7, 1, K_LOAD, 0, 0, 0); cyc("load_prod", 1, 1, 0, 0, 0, 0);
        set_id(0, 0, 7, 1, 0, 0, K_ALU, 0, 0, 0);  cyc("load_use_stall1", 0, 1, 0, 0, 1, 0);
                                                   cyc("load_use_stall2", 0, 1, 0, 0, 1, 0);
                                                   cyc("load_use_fwd", 1, 1, 0, 4, 0, 0);
        set_id(0, 0, 0, 0, 0, 0, K_ALU, 0, 0, 0);  cyc("idle2", 1, 1, 0, 0, 0, 0);

        // JAL links r31
        set_id(0, 0, 0, 0, 31, 1, K_LINK, 0, 0, 0); cyc("jal_prod", 1, 1, 0, 0, 0, 0);
        set_id(31, 1, 7, 1, 0, 0, K_ALU, 0, 0, 0);  cyc("jal_idex", 1, 1, 1, 0, 0, 0);
        set_id(31, 1, 0, 0, 0, 0, K_ALU, 0, 0, 0);  cyc("jal_exmem", 1, 1, 3, 0, 0, 0);
        set_id(0, 0, 31, 1, 0, 0, K_ALU, 0, 0, 0);  cyc("jal_wb", 1, 1, 0, 4, 0, 0);

        // r0 never forwards or stalls
        set_id(0, 1, 0, 1, 0, 1, K_ALU, 0, 0, 0);  cyc("r0_alu", 1, 1, 0, 0, 0, 0);
        set_id(0, 1, 0, 1, 0, 1, K_LOAD, 0, 0, 0); cyc("r0_load", 1, 1, 0, 0, 0, 0);
        set_id(0, 1, 0, 1, 0, 1, K_LINK, 0, 0, 0); cyc("r0_link", 1, 1, 0, 0, 0, 0);
        set_id(0, 1, 0, 1, 0, 0, K_ALU, 0, 0, 0);  cyc("r0_all_slots", 1, 1, 0, 0, 0, 0);

        // MULT then MFLO: four stall cycles
        set_id(1, 1, 2, 1, 0, 0, K_ALU, 0, 1, 0);  cyc("mult_issue", 1, 1, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 9, 1, K_ALU, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc("mflo_wait", 0, 1, 0, 0, 1, 1);
        cyc("mflo_go", 1, 1, 0, 0, 0, 0);

        // MULT stalled on r9 is not accepted until the stall clears
        set_id(9, 1, 0, 0, 0, 0, K_ALU, 0, 1, 0);  cyc("stalled_mult", 0, 1, 0, 0, 1, 0);
                                                   cyc("mult_retry", 1, 1, 2, 0, 0, 0);
        set_id(0, 0, 0, 0, 10, 1, K_ALU, 0, 0, 0); cyc("mult_busy4", 1, 1, 0, 0, 0, 1);
        set_id(0, 0, 0, 0, 11, 1, K_ALU, 0, 0, 0); cyc("mult_busy3", 0, 1, 0, 0, 0, 1);
        set_id(0, 0, 0, 0, 12, 1, K_ALU, 0, 1, 0); cyc("mult_restart", 0, 1, 0, 0, 0, 1);
        set_id(0, 0, 0, 0, 13, 1, K_ALU, 0, 0, 0); cyc("mult_busy_new", 0, 1, 0, 0, 0, 1);

        // reset with three valid slots and counter at 3
        rst = 1'b1;
        set_id(13, 1, 12, 1, 0, 0, K_ALU, 1, 0, 0); cyc("pre_rst", 0, 1, 0, 0, 1, 1);
        rst = 1'b0;
        cyc("post_rst", 1, 1, 0, 0, 0, 0);

`ifdef HAZ_DIV_EN
        set_id(0, 0, 0, 0, 0, 0, K_ALU, 0, 1, 1);  cyc("div_issue", 1, 1, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 9, 1, K_ALU, 1, 0, 0);
        for (int i = 0; i < 32; i++) cyc("mfhi_div_wait", 0, 1, 0, 0, 1, 1);
        cyc("mfhi_div_go", 1, 1, 0, 0, 0, 0);
`else
        set_id(0, 0, 0, 0, 0, 0, K_ALU, 0, 0, 1);  cyc("div_ignored", 1, 1, 0, 0, 0, 0);
        set_id(0, 0, 0, 0, 9, 1, K_ALU, 1, 0, 0);  cyc("mfhi_no_div", 1, 1, 0, 0, 0, 0);
`endif

        set_id(0, 0, 0, 0, 0, 0, K_ALU, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
